// File: rtl/text_write_ctrl_pkg.sv
// Shared constants and types for the text RAM write sequencer.
// ASCII codes, FSM state encoding and default screen geometry.
package text_pkg;

    localparam int DEF_COLS   = 32;
    localparam int DEF_ROWS   = 8;
    localparam int DEF_ADDR_W = 8;

    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_FF    = 8'h0C;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_TILDE = 8'h7E;

    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        IDLE  = 2'd1,
        WRITE = 2'd2
    } text_state_e;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= ASCII_SPACE) && (c <= ASCII_TILDE);
    endfunction

endpackage

// File: rtl/text_write_ctrl_if.sv
// Character stream in, text RAM write port and status out.
// The master side is the producer/observer, the slave side is the sequencer.
interface text_write_if
    import text_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
);
    logic [7:0]        char_in;
    logic              char_valid;
    logic              char_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [7:0]        wdata;
    logic              ram_busy;
    logic [ADDR_W-1:0] cursor_addr;

    modport master (
        output char_in, char_valid,
        input  char_ready, we, waddr, wdata, ram_busy, cursor_addr
    );

    modport slave (
        input  char_in, char_valid,
        output char_ready, we, waddr, wdata, ram_busy, cursor_addr
    );
endinterface

// File: rtl/text_write_ctrl_cursor.sv
// Row/column cursor with advance, newline, backspace and home commands.
// Both counters wrap by natural overflow; prev_addr is the backspace target.
module text_cursor #(
    parameter int COLS = 32,
    parameter int ROWS = 8
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 advance,
    input  logic                                 newline,
    input  logic                                 backspace,
    input  logic                                 home,
    output logic [$clog2(ROWS)+$clog2(COLS)-1:0] addr,
    output logic [$clog2(ROWS)+$clog2(COLS)-1:0] prev_addr,
    output logic                                 at_origin
);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);

    logic [CW-1:0] col_reg;
    logic [RW-1:0] row_reg;
    logic [CW-1:0] prev_col;
    logic [RW-1:0] prev_row;
    logic          col_last;
    logic          col_zero;

    assign col_last  = (col_reg == CW'(COLS - 1));
    assign col_zero  = (col_reg == '0);
    assign at_origin = col_zero && (row_reg == '0);

    // Stepping back from column 0 lands on the last column of the row above.
    assign prev_col  = col_reg - 1'b1;
    assign prev_row  = col_zero ? (row_reg - 1'b1) : row_reg;

    assign addr      = {row_reg, col_reg};
    assign prev_addr = {prev_row, prev_col};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_reg <= '0;
            row_reg <= '0;
        end else if (home) begin
            col_reg <= '0;
            row_reg <= '0;
        end else if (newline) begin
            col_reg <= '0;
            row_reg <= row_reg + 1'b1;
        end else if (advance) begin
            if (col_last) begin
                col_reg <= '0;
                row_reg <= row_reg + 1'b1;
            end else begin
                col_reg <= col_reg + 1'b1;
            end
        end else if (backspace && !at_origin) begin
            col_reg <= prev_col;
            row_reg <= prev_row;
        end
    end

endmodule

// File: rtl/text_write_ctrl.sv
// Owns the text RAM write port: sweeps it with CLEAR_CHAR after reset and
// form feed, then writes accepted characters at a row/column cursor.
module text_write_ctrl
    import text_pkg::*;
#(
    parameter int         COLS       = DEF_COLS,
    parameter int         ROWS       = DEF_ROWS,
    parameter int         ADDR_W     = DEF_ADDR_W,
    parameter logic [7:0] CLEAR_CHAR = ASCII_SPACE
) (
    input  logic        clk,
    input  logic        reset,
    text_write_if.slave bus
);
    localparam logic [1:0] S_CLEAR = CLEAR;
    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_WRITE = WRITE;

    logic [1:0]        state_reg;
    logic [ADDR_W:0]   cnt_reg;
    logic              we_reg;
    logic [ADDR_W-1:0] waddr_reg;
    logic [7:0]        wdata_reg;
    logic              ram_busy_reg;

    logic              accept;
    logic              is_print;
    logic              is_newline;
    logic              is_bs;
    logic              is_ff;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] prev_addr;
    logic              at_origin;

    assign accept     = bus.char_valid && (state_reg == S_IDLE);
    assign is_print   = is_printable(bus.char_in);
    assign is_newline = (bus.char_in == ASCII_LF) || (bus.char_in == ASCII_CR);
    assign is_bs      = (bus.char_in == ASCII_BS);
    assign is_ff      = (bus.char_in == ASCII_FF);

    text_cursor #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_cursor (
        .clk       (clk),
        .reset     (reset),
        .advance   (accept && is_print),
        .newline   (accept && is_newline),
        .backspace (accept && is_bs),
        .home      (accept && is_ff),
        .addr      (cur_addr),
        .prev_addr (prev_addr),
        .at_origin (at_origin)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= S_CLEAR;
            cnt_reg      <= '0;
            we_reg       <= 1'b0;
            waddr_reg    <= '0;
            wdata_reg    <= '0;
            ram_busy_reg <= 1'b1;
        end else begin
            case (state_reg)
                S_CLEAR: begin
                    // The extra counter bit marks the cycle after the last address.
                    if (cnt_reg[ADDR_W]) begin
                        state_reg    <= S_IDLE;
                        cnt_reg      <= '0;
                        we_reg       <= 1'b0;
                        ram_busy_reg <= 1'b0;
                    end else begin
                        we_reg       <= 1'b1;
                        waddr_reg    <= cnt_reg[ADDR_W-1:0];
                        wdata_reg    <= CLEAR_CHAR;
                        ram_busy_reg <= 1'b1;
                        cnt_reg      <= cnt_reg + 1'b1;
                    end
                end
                S_IDLE: begin
                    we_reg <= 1'b0;
                    if (accept) begin
                        if (is_print) begin
                            we_reg    <= 1'b1;
                            waddr_reg <= cur_addr;
                            wdata_reg <= bus.char_in;
                            state_reg <= S_WRITE;
                        end else if (is_bs && !at_origin) begin
                            we_reg    <= 1'b1;
                            waddr_reg <= prev_addr;
                            wdata_reg <= CLEAR_CHAR;
                            state_reg <= S_WRITE;
                        end else if (is_ff) begin
                            cnt_reg   <= '0;
                            state_reg <= S_CLEAR;
                        end
                    end
                end
                S_WRITE: begin
                    we_reg    <= 1'b0;
                    state_reg <= S_IDLE;
                end
                default: begin
                    we_reg    <= 1'b0;
                    state_reg <= S_CLEAR;
                end
            endcase
        end
    end

    assign bus.char_ready  = (state_reg == S_IDLE);
    assign bus.we          = we_reg;
    assign bus.waddr       = waddr_reg;
    assign bus.wdata       = wdata_reg;
    assign bus.ram_busy    = ram_busy_reg;
    assign bus.cursor_addr = cur_addr;

endmodule

// File: doc/text_write_ctrl.md
# text_write_ctrl

Sequencer that owns the write port of the 256-byte text RAM that the VGA text renderer reads. It accepts ASCII characters over a valid/ready stream and maintains a row/column cursor. It interprets control characters (CR/LF, backspace, form feed) and sweeps the whole RAM with spaces on reset and on clear. It drives `ram_busy`, which the renderer uses to blank the screen while the RAM contents are invalid.

## Interface
- `COLS`, 32: characters per row; power of two.
- `ROWS`, 8: rows; power of two; `COLS*ROWS` = 2^`ADDR_W`.
- `ADDR_W`, 8: text RAM address width.
- `CLEAR_CHAR`, 8'h20: fill byte for clear sweeps.
- `clk`  in  1  single system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `char_in`  in  8  ASCII byte offered by the producer (keyboard/UART path).
- `char_valid`  in  1  `char_in` is valid.
- `char_ready`  out  1  block accepts `char_in` on this edge when `char_valid` is also high.
- `we`  out  1  text RAM write enable, one cycle per byte.
- `waddr`  out  `ADDR_W`  write address = {row, col}; row in the MSBs.
- `wdata`  out  8  write data.
- `ram_busy`  out  1  high while a clear sweep is in progress.
- `cursor_addr`  out  `ADDR_W`  current cursor position {row, col}, for cursor overlay.

## Operation
- States:
  - CLEAR: sweeping the RAM.
  - IDLE: ready for input.
  - WRITE: one-cycle write slot.
- Acceptance occurs on an edge where `char_valid && char_ready`. `char_ready` = 1 only in IDLE. Consumed bytes are never re-read.
- Accepted byte handling, cursor (row, col):
  - Printable 0x20–0x7E:
    - Write byte at the cursor.
    - col+1. If col = COLS-1: col 0, row+1.
    - If row = ROWS-1: row wraps to 0. No scroll; old text is overwritten.
  - 0x0A (LF) or 0x0D (CR): col 0, row+1 mod ROWS. No write.
  - 0x08 (BS):
    - If col > 0: col-1.
    - Else if row > 0: row-1, col COLS-1.
    - Else (0,0): no move.
    - When a move occurs, write `CLEAR_CHAR` at the new position. At (0,0), no write.
  - 0x0C (FF): enter CLEAR; cursor to (0,0).
  - Any other byte: consumed and discarded; no write, no move.
- CLEAR: a counter runs from 0 to 2^`ADDR_W`-1. Each cycle: `we`=1, `waddr`=counter, `wdata`=`CLEAR_CHAR`. After the last address the block goes to IDLE.
- Arithmetic: row and col are separate unsigned counters of width log2(ROWS) and log2(COLS). Wrap is natural overflow; no saturation.

## Timing
- Reset values: `we`=0, `waddr`=0, `wdata`=0, `char_ready`=0, `ram_busy`=1, `cursor_addr`=0, state CLEAR, counter 0.
- First edge after reset release: `we`=1, `waddr`=0. The sweep lasts exactly 2^`ADDR_W` write cycles.
- On the edge after the write to the last address: `we`=0, `ram_busy`=0, `char_ready`=1, all together.
- Print/BS with write:
  - Acceptance at edge N.
  - From N to N+1: `we`=1, `waddr`=old cursor (BS: new cursor), and `char_ready`=0 (WRITE state).
  - `cursor_addr` updates at edge N.
  - `char_ready` returns to 1 at edge N+1.
  - Throughput: 1 byte per 2 cycles.
- LF/CR, discarded bytes, BS at (0,0): no WRITE state. `char_ready` stays 1, so back-to-back acceptance is allowed.
- FF accepted at edge N: `ram_busy`=1 and the first sweep write happen at edge N+1. Then the same sweep timing as after reset applies.
- Reset asserted mid-sweep or mid-write: immediate return to reset values. The sweep restarts from address 0.
- `char_valid` dropped while `char_ready`=0: no effect. The producer must hold `char_in` stable until it is accepted.

## Structure
- Package `text_pkg`:
  - ASCII constants: `ASCII_BS`=8'h08, `ASCII_LF`=8'h0A, `ASCII_FF`=8'h0C, `ASCII_CR`=8'h0D, `ASCII_SPACE`=8'h20, `ASCII_TILDE`=8'h7E.
  - State enum {CLEAR, IDLE, WRITE}.
  - Default `COLS`/`ROWS`/`ADDR_W`.
- One sub-module: `text_cursor`. It holds the row/col registers with advance/newline/backspace commands and their wrap logic. The sweep counter and FSM stay in the top.

## Test plan
- Release reset -> exactly 256 cycles with `we`=1, `waddr` 0..255, `wdata` 0x20, `ram_busy`=1. Next edge: `ram_busy`=0, `char_ready`=1.
- Send "AB" after clear -> writes 0x41 @0x00 and 0x42 @0x01. `cursor_addr`=0x02. `char_ready` low one cycle after each acceptance.
- Cursor at 0x1F, send 0x58 -> write @0x1F, `cursor_addr`=0x20. From 0xFF -> write @0xFF, `cursor_addr`=0x00.
- BS sequence:
  - BS at 0x20 -> cursor 0x1F, write 0x20 @0x1F.
  - BS at 0x00 -> no `we`, cursor stays 0x00.
- LF at 0x25 -> cursor 0x40, no `we`, `char_ready` stays 1. Byte 0x07 -> consumed, no effect.
- FF mid-text, then assert `reset` at sweep address 0x80 -> outputs return to reset values. After release, the sweep restarts @0x00 and completes 256 writes.
